// File: rtl/width_12to8_stream_pkg.sv
// Shared widths for the 12-bit to 8-bit stream repacker.
// Imported by the top module and available to the rest of the slice.
package width_12to8_stream_pkg;
    localparam int IN_W     = 12;
    localparam int OUT_W    = 8;
    localparam int NIB_W    = 4;
    localparam int BUF_NIBS = 4;
    localparam int BUF_W    = NIB_W * BUF_NIBS;
    localparam int CNT_W    = 3;
endpackage

// File: rtl/width_12to8_stream.sv
// Repacks 12-bit words into 8-bit bytes through a 4-nibble MSB-aligned buffer.
// Odd-length packets are closed with one zero pad nibble.
module width_12to8_stream
    import width_12to8_stream_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_in,
    input  logic [IN_W-1:0]  data_in,
    input  logic             last_in,
    output logic             ready_up,
    output logic             valid_out,
    output logic [OUT_W-1:0] data_out,
    output logic             last_out,
    input  logic             ready_down
);

    logic [BUF_W-1:0] buf_q, buf_d;
    logic [CNT_W-1:0] nib_cnt, nib_cnt_d;
    logic             last_pend, last_pend_d;
    logic             accept, emit;

    // All outputs decode registered state only, so no input reaches them combinationally.
    assign ready_up  = (nib_cnt <= CNT_W'(1));
    assign valid_out = (nib_cnt >= CNT_W'(2));
    assign data_out  = buf_q[BUF_W-1 -: OUT_W];
    assign last_out  = last_pend && (nib_cnt == CNT_W'(2));

    assign accept = valid_in && ready_up;
    assign emit   = valid_out && ready_down;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
        buf_d       = buf_q;
        nib_cnt_d   = nib_cnt;
        last_pend_d = last_pend;
        if (accept) begin
            if (nib_cnt == '0) begin
                // Low nibble is already zero, which doubles as the pad for a lone last word.
                buf_d     = {data_in, {NIB_W{1'b0}}};
                nib_cnt_d = last_in ? CNT_W'(4) : CNT_W'(3);
            end else begin
                buf_d     = {buf_q[BUF_W-1 -: NIB_W], data_in};
                nib_cnt_d = CNT_W'(4);
            end
            if (last_in) begin
                last_pend_d = 1'b1;
            end
        end else if (emit) begin
            buf_d     = {buf_q[BUF_W-OUT_W-1:0], {OUT_W{1'b0}}};
            nib_cnt_d = nib_cnt - CNT_W'(2);
            if (last_out) begin
                last_pend_d = 1'b0;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q     <= '0;
            nib_cnt   <= '0;
            last_pend <= 1'b0;
        end else begin
            buf_q     <= buf_d;
            nib_cnt   <= nib_cnt_d;
            last_pend <= last_pend_d;
        end
    end

endmodule

// File: tb/tb_width_12to8_stream.sv
// Scoreboard bench for width_12to8_stream: a nibble-stream reference model
// predicts each byte at word acceptance; bytes are compared as they leave.
module tb_width_12to8_stream;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_in = 1'b0;
    logic [11:0] data_in = 12'h000;
    logic        last_in = 1'b0;
    logic        ready_up;
    logic        valid_out;
    logic [7:0]  data_out;
    logic        last_out;
    logic        ready_down = 1'b0;

    int total = 0;
    int bad = 0;
    int cycle = 0;

    logic [8:0] exp_q[$];
    logic [3:0] nib_q[$];
    int         pkt_nibs = 0;
    int         acc_cyc[$];
    int         emit_cyc[$];
    logic       rand_done = 1'b0;

    width_12to8_stream dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .valid_in   (valid_in),
        .data_in    (data_in),
        .last_in    (last_in),
        .ready_up   (ready_up),
        .valid_out  (valid_out),
        .data_out   (data_out),
        .last_out   (last_out),
        .ready_down (ready_down)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Monitor: handshakes seen at negedge complete on the following posedge.
    always @(negedge clk) begin
        logic [3:0] hi, lo;
        logic       lst;
        logic [8:0] e;
        if (rst_n) begin
            if (valid_in && ready_up) begin
                acc_cyc.push_back(cycle);
                nib_q.push_back(data_in[11:8]);
                nib_q.push_back(data_in[7:4]);
                nib_q.push_back(data_in[3:0]);
                pkt_nibs += 3;
                if (last_in && (pkt_nibs % 2 == 1)) nib_q.push_back(4'h0);
                while (nib_q.size() >= 2) begin
                    hi  = nib_q.pop_front();
                    lo  = nib_q.pop_front();
                    lst = last_in && (nib_q.size() == 0);
                    exp_q.push_back({lst, hi, lo});
                end
                if (last_in) pkt_nibs = 0;
            end
            if (valid_out && ready_down) begin
                emit_cyc.push_back(cycle);
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL byte_unexpected: got data=%02h last=%0b, required none", data_out, last_out);
                end else begin
                    e = exp_q.pop_front();
                    if ({last_out, data_out} !== e) begin
                        bad++;
                        $display("FAIL byte_order: got data=%02h last=%0b, required data=%02h last=%0b",
                                 data_out, last_out, e[7:0], e[8]);
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [11:0] d, input logic l);
        int n = 0;
        valid_in = 1'b1;
        data_in  = d;
        last_in  = l;
        forever begin
            @(negedge clk);
            if (ready_up) break;
            n++;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL send_timeout: word %03h not accepted, ready_up=%0b required 1", d, ready_up);
                break;
            end
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || valid_out) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        repeat (3) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if (ready_up !== 1'b1) begin bad++; $display("FAIL reset_ready_up: got %0b required 1", ready_up); end
        total++;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid_out: got %0b required 0", valid_out); end
        total++;
        if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data_out: got %02h required 00", data_out); end
        total++;
        if (last_out !== 1'b0) begin bad++; $display("FAIL reset_last_out: got %0b required 0", last_out); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_pair();
        ready_down = 1'b1;
        send_word(12'hABC, 1'b0);
        send_word(12'hDEF, 1'b1);
        wait_drain();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL pair_drain: %0d bytes left, required 0", exp_q.size()); end
    endtask

    task automatic test_single();
        ready_down = 1'b1;
        send_word(12'h123, 1'b1);
        wait_drain();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL single_drain: %0d bytes left, required 0", exp_q.size()); end
    endtask

    task automatic test_stall();
        ready_down = 1'b0;
        send_word(12'hABC, 1'b0);
        valid_in = 1'b1;
        data_in  = 12'hDEF;
        last_in  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            total++;
            if (valid_out !== 1'b1) begin bad++; $display("FAIL stall_valid: got %0b required 1", valid_out); end
            total++;
            if (data_out !== 8'hAB) begin bad++; $display("FAIL stall_data: got %02h required ab", data_out); end
            total++;
            if (ready_up !== 1'b0) begin bad++; $display("FAIL stall_ready_up: got %0b required 0", ready_up); end
        end
        @(posedge clk);
        #1;
        ready_down = 1'b1;
        send_word(12'hDEF, 1'b1);
        wait_drain();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL stall_drain: %0d bytes left, required 0", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic [11:0] words[4] = '{12'h135, 12'h79B, 12'hDF0, 12'h246};
        ready_down = 1'b1;
        acc_cyc.delete();
        emit_cyc.delete();
        for (int i = 0; i < 4; i++) send_word(words[i], i == 3);
        wait_drain();
        total++;
        if (acc_cyc.size() != 4 || emit_cyc.size() != 6) begin
            bad++;
            $display("FAIL b2b_counts: got %0d words %0d bytes, required 4 words 6 bytes", acc_cyc.size(), emit_cyc.size());
        end else begin
            total++;
            if (emit_cyc[5] - acc_cyc[0] != 9) begin
                bad++;
                $display("FAIL b2b_latency: last byte %0d cycles after first accept, required 9", emit_cyc[5] - acc_cyc[0]);
            end
        end
    endtask

    task automatic test_reset_mid();
        ready_down = 1'b0;
        send_word(12'hABC, 1'b0);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        nib_q.delete();
        pkt_nibs = 0;
        total++;
        if (valid_out !== 1'b0) begin bad++; $display("FAIL midreset_valid: got %0b required 0", valid_out); end
        total++;
        if (ready_up !== 1'b1) begin bad++; $display("FAIL midreset_ready_up: got %0b required 1", ready_up); end
        total++;
        if (data_out !== 8'h00) begin bad++; $display("FAIL midreset_data: got %02h required 00", data_out); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ready_down = 1'b1;
        emit_cyc.delete();
        send_word(12'h456, 1'b1);
        wait_drain();
        total++;
        if (emit_cyc.size() != 2) begin bad++; $display("FAIL midreset_bytes: got %0d bytes required 2", emit_cyc.size()); end
    endtask

    task automatic test_random();
        int words_sent = 0;
        rand_done = 1'b0;
        fork
            begin
                while (words_sent < 1000) begin
                    int len = $urandom_range(1, 5);
                    for (int i = 0; i < len; i++) begin
                        send_word(12'($urandom), (i == len - 1) || (words_sent == 999));
                        words_sent++;
                        if (words_sent == 1000) break;
                        repeat ($urandom_range(0, 2)) begin
                            @(posedge clk);
                            #1;
                        end
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    ready_down = 1'($urandom_range(0, 1));
                end
            end
        join
        ready_down = 1'b1;
        wait_drain();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL random_drain: %0d bytes left, required 0", exp_q.size()); end
        total++;
        if (nib_q.size() != 0) begin bad++; $display("FAIL random_residue: %0d nibbles unpaired, required 0", nib_q.size()); end
    endtask

    initial begin
        test_reset();
        test_pair();
        test_single();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/width_12to8_stream.md
WIDTH_12TO8_STREAM -- requirements
Module: width_12to8_stream

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state updates on posedge clk.
REQ-002 SHALL provide port: rst_n  input  1  reset; asynchronous assertion, active-low.
REQ-003 SHALL provide port: valid_in  input  1  upstream word valid.
REQ-004 SHALL provide port: data_in  input  12  upstream word, MSB transmitted first.
REQ-005 SHALL provide port: last_in  input  1  marks final word of a packet; sampled with data_in.
REQ-006 SHALL provide port: ready_up  output  1  block can accept a word this cycle.
REQ-007 SHALL provide port: valid_out  output  1  output byte valid.
REQ-008 SHALL provide port: data_out  output  8  output byte.
REQ-009 SHALL provide port: last_out  output  1  marks final byte of a packet; qualified by valid_out.
REQ-010 SHALL provide port: ready_down  input  1  downstream accepts a byte this cycle.

Function
REQ-011 SHALL hold a 16-bit nibble buffer buf, MSB-aligned, and a nibble count nib_cnt in 0..4.
REQ-012 SHALL drive ready_up = (nib_cnt <= 1), decoded from registered state only; no combinational path from any input to ready_up.
REQ-013 SHALL accept a word when valid_in && ready_up: append data_in's 3 nibbles after the nib_cnt held nibbles; nib_cnt += 3.
REQ-014 SHALL, when the accepted word has last_in=1 and the new nib_cnt is odd (nib_cnt was 0), append a zero nibble (pad) so nib_cnt becomes 4.
REQ-015 SHALL drive valid_out = (nib_cnt >= 2) and data_out = buf[15:8], both straight from registers.
REQ-016 SHALL emit a byte when valid_out && ready_down: shift buf left by 8, zero-fill, nib_cnt -= 2.
REQ-017 Accept (needs nib_cnt<=1) and emit (needs nib_cnt>=2) SHALL be mutually exclusive by construction; no simultaneous-event case exists.
REQ-018 SHALL keep valid_out, data_out and last_out stable while valid_out=1 and ready_down=0.
REQ-019 SHALL ignore data_in/last_in when ready_up=0; the upstream holds them.
REQ-020 SHALL set a last_pend flag on accepting a last_in word; last_out = last_pend && (nib_cnt == 2); last_pend clears when that byte is emitted.
REQ-021 Byte order SHALL be: word pair A,B -> {A[11:4]}, {A[3:0],B[11:8]}, {B[7:0]}.
REQ-022 Sustained throughput with ready_down=1 SHALL be 2 words per 5 cycles (accept, emit, accept, emit, emit).
REQ-023 An odd-length packet SHALL end with a padded byte {A[3:0],4'h0}; an even-length packet SHALL need no pad.

Reset
REQ-024 On rst_n low SHALL clear buf=0, nib_cnt=0 and last_pend=0 immediately, giving valid_out=0, data_out=8'h00, last_out=0 and ready_up=1.
REQ-025 Reset mid-packet SHALL discard all buffered nibbles; no partial byte appears after release.

Structure
REQ-026 A shared package SHALL hold localparams IN_W=12, OUT_W=8, NIB_W=4, BUF_NIBS=4.
REQ-027 Single flat module; no sub-module; nib_cnt is 3 bits.

Verification
REQ-028 Words 0xABC, 0xDEF (last on second), ready_down=1 -> bytes 0xAB, 0xCD, 0xEF; last_out only with 0xEF.
REQ-029 Single word 0x123 with last_in=1 -> bytes 0x12, 0x30; last_out with 0x30.
REQ-030 Load 0xABC, then ready_down=0 for 5 cycles -> valid_out=1, data_out=0xAB held, ready_up=0; 0xDEF offered meanwhile is not taken until ready_up=1.
REQ-031 Continuous valid_in, ready_down=1, 4 words -> 6 bytes in exactly 10 cycles after the first accept, in REQ-021 order.
REQ-032 Assert rst_n=0 after accepting 0xABC, before any emit -> valid_out=0 and ready_up=1 at once; after release, word 0x456 (last) -> 0x45, 0x60 only.
REQ-033 Random valid_in/ready_down over 1000 words -> output bytes equal the reference nibble stream; no loss, duplication or reorder.
